// File: rtl/register_file.sv
// Architectural register file for the WISC pipeline: NUM_REGS words, R0 reads zero.
// Latency: reads are combinational with same-cycle write bypass; writes land in the array one cycle later.
// Backpressure: none; the busy scoreboard (Busy1/Busy2/PendingCnt) lets ID stall on pending producers.
//
// Ports:
//   clk, rst                      posedge clock, asynchronous active-high reset
//   SrcReg1/2 -> SrcData1/2       combinational read ports (R0 always 0)
//   WriteReg, DstReg, DstData     WB write port
//   ClaimReg, ClaimAddr           ID marks a destination as pending
//   Busy1/2                       read-port register still awaiting its producer
//   PendingCnt                    registered count of busy registers
module register_file #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] SrcReg1,
    input  logic [ADDR_W-1:0] SrcReg2,
    output logic [DATA_W-1:0] SrcData1,
    output logic [DATA_W-1:0] SrcData2,
    input  logic              WriteReg,
    input  logic [ADDR_W-1:0] DstReg,
    input  logic [DATA_W-1:0] DstData,
    input  logic              ClaimReg,
    input  logic [ADDR_W-1:0] ClaimAddr,
    output logic              Busy1,
    output logic              Busy2,
    output logic [ADDR_W:0]   PendingCnt
);

    // Address width must exactly cover the register count.
    generate
        if ($clog2(NUM_REGS) != ADDR_W) begin : g_bad_addr_w
            $error("register_file: ADDR_W must equal $clog2(NUM_REGS)");
        end
    endgenerate

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [ADDR_W:0]     pending_cnt_q;
    logic [ADDR_W:0]     pending_cnt_d;

    // Qualified write/claim: R0 is never written or claimed, and anything
    // presented while reset is asserted is dropped. Gating with rst here also
    // disables the bypass and the busy outputs during reset.
    logic wr_vld;
    logic claim_vld;

    assign wr_vld    = WriteReg && (DstReg != '0) && !rst;
    assign claim_vld = ClaimReg && (ClaimAddr != '0) && !rst;

    // ------------------------------------------------------------------
    // Next-state: register array
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_vld) begin
            regs_d[DstReg] = DstData;
        end
        regs_d[0] = '0;
    end

    // ------------------------------------------------------------------
    // Next-state: busy scoreboard. Claim is applied after the write clear
    // so that a same-cycle claim+write leaves the register busy for the
    // new producer.
    // ------------------------------------------------------------------
    always_comb begin
        busy_d = busy_q;
        if (wr_vld) begin
            busy_d[DstReg] = 1'b0;
        end
        if (claim_vld) begin
            busy_d[ClaimAddr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Popcount of the post-update busy vector; R0 is never busy so the
    // result tops out at NUM_REGS-1 and fits in ADDR_W+1 bits.
    always_comb begin
        pending_cnt_d = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            pending_cnt_d = pending_cnt_d + (ADDR_W + 1)'(busy_d[i]);
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q        <= '0;
            pending_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q        <= busy_d;
            pending_cnt_q <= pending_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Read port 1: R0 -> 0, else same-cycle bypass, else array.
    // ------------------------------------------------------------------
    always_comb begin
        SrcData1 = '0;
        Busy1    = 1'b0;
        if (!rst && (SrcReg1 != '0)) begin
            if (wr_vld && (DstReg == SrcReg1)) begin
                // Data arrives this cycle via the bypass, so it is not busy.
                SrcData1 = DstData;
                Busy1    = 1'b0;
            end else begin
                SrcData1 = regs_q[SrcReg1];
                Busy1    = busy_q[SrcReg1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read port 2: identical to port 1, fully independent.
    // ------------------------------------------------------------------
    always_comb begin
        SrcData2 = '0;
        Busy2    = 1'b0;
        if (!rst && (SrcReg2 != '0)) begin
            if (wr_vld && (DstReg == SrcReg2)) begin
                SrcData2 = DstData;
                Busy2    = 1'b0;
            end else begin
                SrcData2 = regs_q[SrcReg2];
                Busy2    = busy_q[SrcReg2];
            end
        end
    end

    assign PendingCnt = pending_cnt_q;

endmodule
